// File: rtl/regfile_banked.sv
// Banked integer/FP register file: FP pair writes with index wrap-around,
// same-cycle write-to-read bypass, and a one-entry-per-cycle clear sequence.
module regfile_banked #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   input  logic              wr_en,
   input  logic              wr_fp,
   input  logic              wr_pair,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic              rd_fp0,
   output logic [DATA_W-1:0] rd_data0_0,
   output logic [DATA_W-1:0] rd_data0_1,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic              rd_fp1,
   output logic [DATA_W-1:0] rd_data1_0,
   output logic [DATA_W-1:0] rd_data1_1
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [DATA_W-1:0] r_int_bank [DEPTH];
   logic [DATA_W-1:0] r_fp_bank  [DEPTH];

   logic              w_wr_fire;
   logic              w_int_wr;
   logic              w_fp_wr0;
   logic              w_fp_wr1;
   logic              w_clr_last;
   logic [ADDR_W-1:0] w_wr_addr_hi;

   logic [ADDR_W-1:0] w_rd_addr    [2];
   logic              w_rd_fp      [2];
   logic [ADDR_W-1:0] w_rd_addr_hi [2];
   logic [DATA_W-1:0] w_rd_lo      [2];
   logic [DATA_W-1:0] w_rd_hi      [2];

   assign busy       = (r_state == ST_CLEAR);
   assign wr_ready   = (r_state == ST_IDLE);
   assign w_clr_last = busy && (r_cnt == ADDR_W'(DEPTH - 1));
   assign clr_done   = w_clr_last;

   // rst_n gates the fire so bypass cannot push write data onto reads during reset.
   assign w_wr_fire    = wr_en && wr_ready && rst_n;
   assign w_int_wr     = w_wr_fire && !wr_fp && !((ZERO_REG != 0) && (wr_addr == '0));
   assign w_fp_wr0     = w_wr_fire && wr_fp;
   assign w_fp_wr1     = w_fp_wr0 && wr_pair;
   assign w_wr_addr_hi = wr_addr + ADDR_W'(1);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= busy ? r_cnt + ADDR_W'(1) : '0;
      end
   end

   // NOTE: the banks are flops with an async reset because reset must zero every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_int_bank[i] <= '0;
            r_fp_bank[i]  <= '0;
         end
      end else if (busy) begin
         r_int_bank[r_cnt] <= '0;
         r_fp_bank[r_cnt]  <= '0;
      end else begin
         if (w_int_wr) r_int_bank[wr_addr]     <= wr_data0;
         if (w_fp_wr0) r_fp_bank[wr_addr]      <= wr_data0;
         if (w_fp_wr1) r_fp_bank[w_wr_addr_hi] <= wr_data1;
      end
   end

   assign w_rd_addr[0] = rd_addr0;
   assign w_rd_addr[1] = rd_addr1;
   assign w_rd_fp[0]   = rd_fp0;
   assign w_rd_fp[1]   = rd_fp1;

   // Reads see the value the array will hold after this edge's write.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_addr_hi[p] = w_rd_addr[p] + ADDR_W'(1);
         if (w_rd_fp[p]) begin
            w_rd_lo[p] = r_fp_bank[w_rd_addr[p]];
            if (w_fp_wr0 && (wr_addr == w_rd_addr[p]))      w_rd_lo[p] = wr_data0;
            if (w_fp_wr1 && (w_wr_addr_hi == w_rd_addr[p])) w_rd_lo[p] = wr_data1;
         end else begin
            w_rd_lo[p] = r_int_bank[w_rd_addr[p]];
            if (w_int_wr && (wr_addr == w_rd_addr[p]))      w_rd_lo[p] = wr_data0;
            if ((ZERO_REG != 0) && (w_rd_addr[p] == '0))    w_rd_lo[p] = '0;
         end
         w_rd_hi[p] = r_fp_bank[w_rd_addr_hi[p]];
         if (w_fp_wr0 && (wr_addr == w_rd_addr_hi[p]))      w_rd_hi[p] = wr_data0;
         if (w_fp_wr1 && (w_wr_addr_hi == w_rd_addr_hi[p])) w_rd_hi[p] = wr_data1;
      end
   end

   assign rd_data0_0 = w_rd_lo[0];
   assign rd_data0_1 = w_rd_hi[0];
   assign rd_data1_0 = w_rd_lo[1];
   assign rd_data1_1 = w_rd_hi[1];

endmodule

// File: tb/tb_regfile_banked.sv
// Self-checking bench for regfile_banked: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_banked;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr_req;
   logic          busy;
   logic          clr_done;
   logic          wr_en;
   logic          wr_fp;
   logic          wr_pair;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data0;
   logic [DW-1:0] wr_data1;
   logic          wr_ready;
   logic [AW-1:0] rd_addr0;
   logic          rd_fp0;
   logic [DW-1:0] rd_data0_0;
   logic [DW-1:0] rd_data0_1;
   logic [AW-1:0] rd_addr1;
   logic          rd_fp1;
   logic [DW-1:0] rd_data1_0;
   logic [DW-1:0] rd_data1_1;

   regfile_banked #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
      .wr_en(wr_en), .wr_fp(wr_fp), .wr_pair(wr_pair), .wr_addr(wr_addr),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ready(wr_ready),
      .rd_addr0(rd_addr0), .rd_fp0(rd_fp0), .rd_data0_0(rd_data0_0), .rd_data0_1(rd_data0_1),
      .rd_addr1(rd_addr1), .rd_fp1(rd_fp1), .rd_data1_0(rd_data1_0), .rd_data1_1(rd_data1_1)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: plain arrays plus the position of a running clear (-1 = none).
   logic [DW-1:0] m_int [DEPTH];
   logic [DW-1:0] m_fp  [DEPTH];
   int            clr_pos = -1;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_int[i] = '0;
         m_fp[i]  = '0;
      end
      clr_pos = -1;
   endtask

   // Value a read observes: the array content after this cycle's accepted write.
   function automatic logic [DW-1:0] view(input bit fp, input int a);
      logic [DW-1:0] v;
      bit fire;
      fire = wr_en && (clr_pos < 0) && rst_n;
      v = fp ? m_fp[a] : m_int[a];
      if (fire) begin
         if (!wr_fp && !fp && a == int'(wr_addr)) v = wr_data0;
         if (wr_fp && fp && a == int'(wr_addr)) v = wr_data0;
         if (wr_fp && wr_pair && fp && a == (int'(wr_addr) + 1) % DEPTH) v = wr_data1;
      end
      if (!fp && a == 0) v = '0;
      return v;
   endfunction

   task automatic check_all();
      bit clearing;
      if (!rst_n) model_reset();
      clearing = (clr_pos >= 0);
      check("busy",     {31'b0, busy},     {31'b0, clearing});
      check("wr_ready", {31'b0, wr_ready}, {31'b0, !clearing});
      check("clr_done", {31'b0, clr_done}, {31'b0, clr_pos == DEPTH - 1});
      check("rd0_0", rd_data0_0, view(rd_fp0, int'(rd_addr0)));
      check("rd0_1", rd_data0_1, view(1'b1, (int'(rd_addr0) + 1) % DEPTH));
      check("rd1_0", rd_data1_0, view(rd_fp1, int'(rd_addr1)));
      check("rd1_1", rd_data1_1, view(1'b1, (int'(rd_addr1) + 1) % DEPTH));
   endtask

   task automatic model_update();
      if (!rst_n) begin
         model_reset();
      end else if (clr_pos < 0) begin
         if (wr_en) begin
            if (!wr_fp) begin
               if (wr_addr != 0) m_int[wr_addr] = wr_data0;
            end else begin
               m_fp[wr_addr] = wr_data0;
               if (wr_pair) m_fp[(int'(wr_addr) + 1) % DEPTH] = wr_data1;
            end
         end
         if (clr_req) clr_pos = 0;
      end else begin
         m_int[clr_pos] = '0;
         m_fp[clr_pos]  = '0;
         clr_pos++;
         if (clr_pos == DEPTH) clr_pos = -1;
      end
   endtask

   // Inputs are set at the falling edge; check mid-cycle, then advance one clock.
   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic quiet();
      clr_req  = 1'b0;
      wr_en    = 1'b0;
      wr_fp    = 1'b0;
      wr_pair  = 1'b0;
      wr_addr  = '0;
      wr_data0 = '0;
      wr_data1 = '0;
      rd_addr0 = '0;
      rd_fp0   = 1'b0;
      rd_addr1 = '0;
      rd_fp1   = 1'b0;
   endtask

   task automatic write(input bit fp, input bit pair, input int a, input logic [DW-1:0] d0,
                        input logic [DW-1:0] d1);
      wr_en    = 1'b1;
      wr_fp    = fp;
      wr_pair  = pair;
      wr_addr  = AW'(a);
      wr_data0 = d0;
      wr_data1 = d1;
   endtask

   task automatic random_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         wr_en    = ($urandom_range(3) != 0);
         wr_fp    = $urandom_range(1);
         wr_pair  = $urandom_range(1);
         case ($urandom_range(5))
            0:       wr_addr = '0;
            1:       wr_addr = AW'(DEPTH - 1);
            default: wr_addr = AW'($urandom_range(DEPTH - 1));
         endcase
         wr_data0 = $urandom;
         wr_data1 = $urandom;
         rd_addr0 = $urandom_range(1) ? wr_addr : AW'($urandom_range(DEPTH - 1));
         rd_addr1 = $urandom_range(1) ? wr_addr + AW'(1) : AW'($urandom_range(DEPTH - 1));
         rd_fp0   = $urandom_range(1);
         rd_fp1   = $urandom_range(1);
         clr_req  = ($urandom_range(59) == 0);
         step();
      end
   endtask

   initial begin
      quiet();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset values
      rd_addr0 = AW'(9);
      rd_fp0   = 1'b1;
      #1;
      check("rst_busy",  {31'b0, busy},     32'd0);
      check("rst_ready", {31'b0, wr_ready}, 32'd1);
      check("rst_rd",    rd_data0_0,        32'd0);
      step();
      rst_n = 1'b1;

      // Integer write/read and zero register
      quiet();
      write(1'b0, 1'b0, 3, 32'hDEADBEEF, 32'h0);
      step();
      quiet();
      rd_addr0 = AW'(3);
      #1;
      check("int3", rd_data0_0, 32'hDEADBEEF);
      step();
      write(1'b0, 1'b0, 0, 32'h1234, 32'h0);
      step();
      quiet();
      #1;
      check("int0", rd_data0_0, 32'h0);
      step();

      // FP pair write wrapping from the top index to 0
      write(1'b1, 1'b1, DEPTH - 1, 32'hAAAA0000, 32'h5555FFFF);
      step();
      quiet();
      rd_addr0 = AW'(DEPTH - 1);
      rd_fp0   = 1'b1;
      rd_addr1 = AW'(0);
      rd_fp1   = 1'b1;
      #1;
      check("wrap_lo",  rd_data0_0, 32'hAAAA0000);
      check("wrap_hi",  rd_data0_1, 32'h5555FFFF);
      check("wrap_fp0", rd_data1_0, 32'h5555FFFF);
      step();

      // Same-cycle bypass on a pair write
      write(1'b1, 1'b1, 4, 32'hCAFE0004, 32'hBEEF0005);
      rd_addr1 = AW'(4);
      rd_fp1   = 1'b1;
      rd_addr0 = AW'(3);
      rd_fp0   = 1'b0;
      #1;
      check("byp_lo",    rd_data1_0, 32'hCAFE0004);
      check("byp_hi",    rd_data1_1, 32'hBEEF0005);
      check("byp_other", rd_data0_0, 32'hDEADBEEF);
      step();
      quiet();

      // Fill, then clear with a simultaneous write and a repeated request
      for (int i = 0; i < DEPTH; i++) begin
         write(1'b1, 1'b0, i, $urandom | 32'h1, 32'h0);
         step();
         write(1'b0, 1'b0, i, $urandom | 32'h1, 32'h0);
         step();
      end
      quiet();
      write(1'b0, 1'b0, 5, 32'h0000_0555, 32'h0);
      clr_req = 1'b1;
      step();
      for (int k = 1; k <= DEPTH; k++) begin
         write(1'b0, 1'b0, 6, 32'hBAD0_0006, 32'h0);
         clr_req  = (k == 5);
         rd_addr0 = AW'(k % DEPTH);
         #1;
         check("clr_busy",  {31'b0, busy},     32'd1);
         check("clr_ready", {31'b0, wr_ready}, 32'd0);
         check("clr_done",  {31'b0, clr_done}, {31'b0, k == DEPTH});
         step();
      end
      quiet();
      #1;
      check("clr_end_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr0 = AW'(i);
         rd_fp0   = 1'b0;
         rd_addr1 = AW'(i);
         rd_fp1   = 1'b1;
         #1;
         check("clr_int", rd_data0_0, 32'h0);
         check("clr_fp",  rd_data1_0, 32'h0);
         step();
      end

      random_cycles(1500);

      // Reset in the middle of a clear
      quiet();
      for (int i = 1; i < DEPTH; i++) begin
         write(i % 2 == 1, 1'b0, i, $urandom | 32'h1, 32'h0);
         step();
      end
      quiet();
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (10) step();
      rst_n    = 1'b0;
      rd_addr0 = AW'(20);
      rd_addr1 = AW'(21);
      rd_fp1   = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_int",  rd_data0_0,    32'h0);
      check("mid_rst_fp",   rd_data1_0,    32'h0);
      step();
      rst_n = 1'b1;
      write(1'b0, 1'b0, 7, 32'h7777_0007, 32'h0);
      #1;
      check("post_rst_ready", {31'b0, wr_ready}, 32'd1);
      step();
      quiet();
      rd_addr0 = AW'(7);
      #1;
      check("post_rst_int7", rd_data0_0, 32'h7777_0007);
      step();

      random_cycles(1500);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_banked.md
REGFILE_BANKED -- requirements
Module: regfile_banked

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 32, word width of both banks.
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W entries per bank; ADDR_W >= 1.
- ZERO_REG, 1, when 1, integer entry 0 is hardwired to zero.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clr_req, in, 1, request a sequential clear of both banks.
- busy, out, 1, high while a clear sequence is running.
- clr_done, out, 1, one-cycle pulse on the last clear cycle.
- wr_en, in, 1, write request.
- wr_fp, in, 1, write targets the FP bank (0 = integer bank).
- wr_pair, in, 1, FP pair write: also writes wr_data1 to wr_addr+1.
- wr_addr, in, ADDR_W, write index.
- wr_data0, in, DATA_W, data for wr_addr.
- wr_data1, in, DATA_W, data for the pair upper entry.
- wr_ready, out, 1, write accepted this cycle.
- rd_addrN, in, ADDR_W, read index for port N (N = 0, 1).
- rd_fpN, in, 1, port N reads the FP bank.
- rd_dataN_0, out, DATA_W, bank[rd_addrN].
- rd_dataN_1, out, DATA_W, FP bank[rd_addrN+1], regardless of rd_fpN.

Function
REQ-003 The block SHALL hold two arrays, int_bank and fp_bank, each DEPTH x DATA_W, in flops.
REQ-004 The FSM SHALL have two states: IDLE and CLEAR. busy = (state == CLEAR). wr_ready = (state == IDLE).
REQ-005 A write SHALL commit at the rising edge iff wr_en && wr_ready. Write latency is one cycle.
REQ-006 An integer write (wr_fp = 0) SHALL update int_bank[wr_addr] only. wr_pair SHALL be ignored for integer writes.
REQ-007 When ZERO_REG = 1, an integer write to index 0 SHALL be discarded, and int_bank reads of index 0 SHALL return 0.
REQ-008 An FP write SHALL update fp_bank[wr_addr] with wr_data0. If wr_pair = 1, it SHALL also update fp_bank[(wr_addr+1) mod DEPTH] with wr_data1; DEPTH-1 wraps to 0.
REQ-009 Reads SHALL be combinational, with zero latency.
REQ-010 Pair address arithmetic SHALL be ADDR_W bits, mod DEPTH, with no error flag.
REQ-011 Bypass: when a write commits this cycle to the same bank and index a read port addresses, that read output SHALL return the incoming write data (wr_data0 or wr_data1 as appropriate) instead of the array contents. Bypass SHALL apply to both _0 and _1 outputs. No bypass SHALL occur for discarded zero-register writes.
REQ-012 IDLE -> CLEAR SHALL occur on clr_req = 1 in IDLE. In that cycle wr_ready = 1, so a simultaneous write commits and is then cleared by the sequence.
REQ-013 On entry to CLEAR, the clear counter SHALL be 0. Each CLEAR cycle SHALL zero int_bank[cnt] and fp_bank[cnt], then increment cnt.
REQ-014 When cnt == DEPTH-1, clr_done SHALL be 1 for that cycle. The next state SHALL be IDLE. A clear therefore lasts exactly DEPTH cycles.
REQ-015 clr_req SHALL be ignored while in CLEAR, with no restart and no queuing.
REQ-016 While in CLEAR, writes SHALL be rejected (wr_ready = 0). The requester must hold wr_en until wr_ready is high; the block stores nothing.
REQ-017 While in CLEAR, reads SHALL return current array contents: entries already cleared read 0, entries not yet cleared hold their old values.

Reset
REQ-018 rst_n low SHALL, asynchronously and immediately, zero all entries of both banks, set the state to IDLE, and set cnt to 0.
REQ-019 Output values during reset SHALL be: busy = 0, clr_done = 0, wr_ready = 1, and all rd_data outputs 0.
REQ-020 Reset asserted mid-clear SHALL abort the sequence. After rst_n is released, the block SHALL be in IDLE with no pending clear.
REQ-021 Deassertion of rst_n is synchronised externally. The first write SHALL be allowed on the first edge after release.

Verification
REQ-022 Int write/read: write int idx 3 = 0xDEADBEEF. Next cycle, rd_addr0 = 3, rd_fp0 = 0 -> rd_data0_0 = 0xDEADBEEF. Write int idx 0 = 0x1234 -> idx 0 still reads 0.
REQ-023 FP pair wrap: FP pair write at addr 31 with 0xAAAA0000 / 0x5555FFFF -> fp[31] = 0xAAAA0000, fp[0] = 0x5555FFFF. A read at addr 31 gives _0 = 0xAAAA0000 and _1 = 0x5555FFFF.
REQ-024 Bypass: same-cycle FP pair write at addr 4 and read port 1 at addr 4 -> rd_data1_0 = wr_data0 and rd_data1_1 = wr_data1 in that cycle. rd_data0 of an untouched index is unaffected.
REQ-025 Clear: fill all entries, then pulse clr_req together with a write to idx 5. Required response: busy = 1 for 32 cycles, wr_ready = 0 throughout, clr_done on cycle 32, and all entries read 0 afterwards, including idx 5. A second clr_req mid-sequence does not extend it.
REQ-026 Reset mid-clear: assert rst_n = 0 at clear cycle 10 -> busy = 0 immediately, all reads 0. After release, wr_ready = 1 and a write to idx 7 succeeds.
